// File: rtl/mmio_instr_decoder_if.sv
// Bus bundle between the instruction decoder, its BRAM port B and the layer controller.
// master = decoder side, slave = BRAM/consumer side.
interface mmio_instr_decoder_if #(
  parameter int ROW_WIDTH = 10
);
  logic                 start;
  logic [31:0]          base_addr;
  logic [31:0]          bram_addrb;
  logic                 bram_enb;
  logic [7:0]           bram_web;
  logic [63:0]          bram_dinb;
  logic [63:0]          bram_doutb;
  logic                 instr_valid;
  logic                 instr_ready;
  logic [2:0]           opcode;
  logic [ROW_WIDTH-1:0] in_row;
  logic [ROW_WIDTH-1:0] in_col;
  logic [2:0]           kernel;
  logic [1:0]           stride;
  logic [1:0]           padding;
  logic [1:0]           slice_count;
  logic [11:0]          in_ch;
  logic [11:0]          out_ch;
  logic [ROW_WIDTH-1:0] out_row;
  logic [ROW_WIDTH-1:0] out_col;
  logic                 busy;
  logic                 done;
  logic                 error;

  modport master (
    input  start, base_addr, bram_doutb, instr_ready,
    output bram_addrb, bram_enb, bram_web, bram_dinb, instr_valid,
           opcode, in_row, in_col, kernel, stride, padding, slice_count,
           in_ch, out_ch, out_row, out_col, busy, done, error
  );

  modport slave (
    output start, base_addr, bram_doutb, instr_ready,
    input  bram_addrb, bram_enb, bram_web, bram_dinb, instr_valid,
           opcode, in_row, in_col, kernel, stride, padding, slice_count,
           in_ch, out_ch, out_row, out_col, busy, done, error
  );
endinterface

// File: rtl/mmio_instr_decoder.sv
// Fetches 64-bit layer instructions from BRAM port B, decodes them and issues them over valid/ready.
// Optional macro IFD_FIELD_CHECK_EN: also reject instructions with illegal kernel/stride/size fields.
module mmio_instr_decoder #(
  parameter int ROW_WIDTH    = 10,
  parameter int BRAM_LATENCY = 2,
  parameter int ADDR_STEP    = 1
) (
  input logic                  clk,
  input logic                  reset,
  mmio_instr_decoder_if.master bus
);
  typedef logic [ROW_WIDTH-1:0] row_t;
  typedef logic [ROW_WIDTH+1:0] span_t;
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT, S_DECODE, S_ISSUE, S_DONE, S_ERR
  } state_e;

  localparam logic [1:0] WAIT_LAST = 2'(BRAM_LATENCY - 1);

  state_e      state_q;
  logic [31:0] pc_q, addr_q;
  logic        enb_q, valid_q, busy_q, done_q, error_q;
  logic [1:0]  wait_cnt_q;
  logic [63:0] word_q;
  logic [2:0]  opcode_q, kernel_q;
  row_t        in_row_q, in_col_q, out_row_q, out_col_q;
  logic [1:0]  stride_q, padding_q, slice_q;
  logic [11:0] in_ch_q, out_ch_q;

  logic [2:0]  opcode_d, kernel_d;
  row_t        in_row_d, in_col_d, out_row_d, out_col_d;
  logic [1:0]  stride_d, padding_d, shamt_d;
  logic [11:0] in_ch_d, out_ch_d;
  span_t       row_sum_d, col_sum_d, row_span_d, col_span_d;
  logic [31:0] pc_next_d;
  logic        reserved_d, field_bad_d;
  logic        unused_word;

  assign opcode_d  = word_q[63:61];
  assign in_row_d  = row_t'(word_q[60:51]);
  assign in_col_d  = row_t'(word_q[50:41]);
  assign kernel_d  = word_q[40:38];
  assign stride_d  = word_q[37:36];
  assign padding_d = word_q[35:34];
  assign in_ch_d   = word_q[31:20];
  assign out_ch_d  = word_q[19:8];
  assign unused_word = ^word_q[7:0];

  // Output size: ((in + 2*pad - k) >> (stride-1)) + 1, evaluated two bits wider than a row.
  assign row_sum_d  = span_t'(in_row_d) + span_t'({padding_d, 1'b0});
  assign col_sum_d  = span_t'(in_col_d) + span_t'({padding_d, 1'b0});
  assign row_span_d = row_sum_d - span_t'(kernel_d);
  assign col_span_d = col_sum_d - span_t'(kernel_d);
  assign shamt_d    = stride_d - 2'd1;
  assign out_row_d  = row_t'((row_span_d >> shamt_d) + span_t'(1));
  assign out_col_d  = row_t'((col_span_d >> shamt_d) + span_t'(1));

  assign reserved_d = (opcode_d[2:1] != 2'b00);
  assign pc_next_d  = pc_q + 32'(ADDR_STEP);

`ifdef IFD_FIELD_CHECK_EN
  assign field_bad_d = !(kernel_d == 3'd1 || kernel_d == 3'd3) ||
                       !(stride_d == 2'd1 || stride_d == 2'd2) ||
                       (in_row_d == '0) || (in_col_d == '0) ||
                       (in_ch_d == '0) || (out_ch_d == '0) ||
                       (row_sum_d < span_t'(kernel_d));
`else
  assign field_bad_d = 1'b0;
`endif

  // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      addr_q     <= '0;
      enb_q      <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      wait_cnt_q <= '0;
      word_q     <= '0;
      opcode_q   <= '0;
      kernel_q   <= '0;
      in_row_q   <= '0;
      in_col_q   <= '0;
      out_row_q  <= '0;
      out_col_q  <= '0;
      stride_q   <= '0;
      padding_q  <= '0;
      slice_q    <= '0;
      in_ch_q    <= '0;
      out_ch_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE, S_ERR: begin
          if (bus.start) begin
            pc_q    <= bus.base_addr;
            addr_q  <= bus.base_addr;
            enb_q   <= 1'b1;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            state_q <= S_FETCH;
          end
        end
        S_FETCH: begin
          enb_q      <= 1'b0;
          wait_cnt_q <= '0;
          state_q    <= S_WAIT;
        end
        S_WAIT: begin
          if (wait_cnt_q == WAIT_LAST) begin
            word_q  <= bus.bram_doutb;
            state_q <= S_DECODE;
          end else begin
            wait_cnt_q <= wait_cnt_q + 2'd1;
          end
        end
        S_DECODE: begin
          opcode_q  <= opcode_d;
          in_row_q  <= in_row_d;
          in_col_q  <= in_col_d;
          kernel_q  <= kernel_d;
          stride_q  <= stride_d;
          padding_q <= padding_d;
          slice_q   <= word_q[33:32];
          in_ch_q   <= in_ch_d;
          out_ch_q  <= out_ch_d;
          out_row_q <= out_row_d;
          out_col_q <= out_col_d;
          // END wins over every other check, including the field checks.
          if (opcode_d == 3'b111) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_DONE;
          end else if (reserved_d || field_bad_d) begin
            error_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_ERR;
          end else begin
            valid_q <= 1'b1;
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (bus.instr_ready) begin
            valid_q <= 1'b0;
            pc_q    <= pc_next_d;
            addr_q  <= pc_next_d;
            enb_q   <= 1'b1;
            state_q <= S_FETCH;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.bram_addrb  = addr_q;
  assign bus.bram_enb    = enb_q;
  assign bus.bram_web    = 8'h00;
  assign bus.bram_dinb   = 64'h0;
  assign bus.instr_valid = valid_q;
  assign bus.opcode      = opcode_q;
  assign bus.in_row      = in_row_q;
  assign bus.in_col      = in_col_q;
  assign bus.kernel      = kernel_q;
  assign bus.stride      = stride_q;
  assign bus.padding     = padding_q;
  assign bus.slice_count = slice_q;
  assign bus.in_ch       = in_ch_q;
  assign bus.out_ch      = out_ch_q;
  assign bus.out_row     = out_row_q;
  assign bus.out_col     = out_col_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.error       = error_q;
endmodule

// File: tb/tb_mmio_instr_decoder.sv
// Bench for mmio_instr_decoder: three instances (BRAM latency 1, 2, 3) share one stimulus and memory,
// each checked every cycle against a transaction-level model plus directed literal expectations.
`timescale 1ns/1ps
module tb_mmio_instr_decoder;
  localparam logic [63:0] JUNK  = 64'hA5A5_A5A5_A5A5_A5A5;
  localparam logic [63:0] W_END = {3'b111, 61'h0};
  localparam logic [63:0] W1    = {3'b001, 10'd640, 10'd8, 3'd3, 2'd2, 2'd2, 2'd1, 12'd20, 12'd40, 8'h00};
  localparam logic [63:0] W2    = {3'b000, 10'd10, 10'd10, 3'd1, 2'd1, 2'd0, 2'd0, 12'd20, 12'd20, 8'h00};
  localparam logic [63:0] W_RSV = {3'b100, 10'd10, 10'd10, 3'd1, 2'd1, 2'd0, 2'd0, 12'd20, 12'd20, 8'h00};
  localparam logic [63:0] W_K2  = {3'b001, 10'd10, 10'd10, 3'd2, 2'd1, 2'd0, 2'd0, 12'd20, 12'd20, 8'h00};

  localparam logic [1:0] K_ISSUE = 2'd0, K_END = 2'd1, K_ERR = 2'd2;
  localparam int P_IDLE = 0, P_FLIGHT = 1, P_ISSUE = 2;

  typedef struct packed {
    logic [2:0]  opcode;
    logic [9:0]  in_row, in_col;
    logic [2:0]  kernel;
    logic [1:0]  stride, padding, slice_count;
    logic [11:0] in_ch, out_ch;
    logic [9:0]  out_row, out_col;
    logic [1:0]  kind;
  } dec_t;

  logic        clk = 1'b0;
  logic        rst_r = 1'b1;
  logic        start_r = 1'b0;
  logic [31:0] base_r = '0;
  logic        ready_r = 1'b0;
  logic [63:0] mem [16];
  int          vectors = 0;
  int          miscompares = 0;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Instruction meaning straight from the field layout and the output-size formula.
  function automatic dec_t decode(input logic [63:0] w);
    dec_t d;
    int   rs, cs, sh;
    d.opcode      = w[63:61];
    d.in_row      = w[60:51];
    d.in_col      = w[50:41];
    d.kernel      = w[40:38];
    d.stride      = w[37:36];
    d.padding     = w[35:34];
    d.slice_count = w[33:32];
    d.in_ch       = w[31:20];
    d.out_ch      = w[19:8];
    sh = (int'(d.stride) + 3) % 4;
    rs = (int'(d.in_row) + 2 * int'(d.padding) - int'(d.kernel)) & 'hFFF;
    cs = (int'(d.in_col) + 2 * int'(d.padding) - int'(d.kernel)) & 'hFFF;
    d.out_row = 10'(((rs >> sh) + 1) & 'h3FF);
    d.out_col = 10'(((cs >> sh) + 1) & 'h3FF);
    if (d.opcode == 3'b111)      d.kind = K_END;
    else if (d.opcode > 3'b001)  d.kind = K_ERR;
    else                         d.kind = K_ISSUE;
`ifdef IFD_FIELD_CHECK_EN
    if (d.kind == K_ISSUE &&
        (!(d.kernel inside {3'd1, 3'd3}) || !(d.stride inside {2'd1, 2'd2}) ||
         d.in_row == 0 || d.in_col == 0 || d.in_ch == 0 || d.out_ch == 0 ||
         int'(d.in_row) + 2 * int'(d.padding) < int'(d.kernel)))
      d.kind = K_ERR;
`endif
    return d;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int L = g + 1;
    mmio_instr_decoder_if #(.ROW_WIDTH(10)) u_if ();
    mmio_instr_decoder #(.ROW_WIDTH(10), .BRAM_LATENCY(L), .ADDR_STEP(1)) u_dut (
      .clk  (clk),
      .reset(rst_r),
      .bus  (u_if.master)
    );

    logic [63:0] pipe [L];
    assign u_if.start       = start_r;
    assign u_if.base_addr   = base_r;
    assign u_if.instr_ready = ready_r;
    assign u_if.bram_doutb  = pipe[L-1];

    // BRAM port B: read data valid L cycles after enb, junk on every other cycle.
    always @(posedge clk) begin
      pipe[0] <= u_if.bram_enb ? mem[u_if.bram_addrb[3:0]] : JUNK;
      for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end

    string       tag;
    int          phase, cyc, fetch_cyc, enb_cyc, lat, valid_count;
    logic [31:0] pc_m, addr_m;
    logic        enb_m, valid_m, busy_m, done_m, err_m, armed, prev_valid;
    dec_t        exp_m;

    initial begin
      tag = $sformatf("L%0d", L);
      phase = P_IDLE; cyc = 0; fetch_cyc = 0; enb_cyc = 0; lat = 0; valid_count = 0;
      pc_m = '0; addr_m = '0; exp_m = '0;
      enb_m = 0; valid_m = 0; busy_m = 0; done_m = 0; err_m = 0; armed = 0; prev_valid = 0;
      forever begin
        @(negedge clk);
        cyc++;
        if (armed) begin
          check({tag, " enb"},   u_if.bram_enb,    enb_m);
          check({tag, " valid"}, u_if.instr_valid, valid_m);
          check({tag, " busy"},  u_if.busy,        busy_m);
          check({tag, " done"},  u_if.done,        done_m);
          check({tag, " error"}, u_if.error,       err_m);
          check({tag, " web"},   u_if.bram_web,    8'h00);
          check({tag, " dinb"},  u_if.bram_dinb,   64'h0);
          if (enb_m) check({tag, " addr"}, u_if.bram_addrb, addr_m);
          if (valid_m) begin
            check({tag, " opcode"},  u_if.opcode,      exp_m.opcode);
            check({tag, " in_row"},  u_if.in_row,      exp_m.in_row);
            check({tag, " in_col"},  u_if.in_col,      exp_m.in_col);
            check({tag, " kernel"},  u_if.kernel,      exp_m.kernel);
            check({tag, " stride"},  u_if.stride,      exp_m.stride);
            check({tag, " padding"}, u_if.padding,     exp_m.padding);
            check({tag, " slices"},  u_if.slice_count, exp_m.slice_count);
            check({tag, " in_ch"},   u_if.in_ch,       exp_m.in_ch);
            check({tag, " out_ch"},  u_if.out_ch,      exp_m.out_ch);
            check({tag, " out_row"}, u_if.out_row,     exp_m.out_row);
            check({tag, " out_col"}, u_if.out_col,     exp_m.out_col);
          end
        end
        if (u_if.bram_enb) enb_cyc = cyc;
        if (u_if.instr_valid && !prev_valid) begin
          lat = cyc - enb_cyc;
          valid_count++;
        end
        prev_valid = u_if.instr_valid;

        // Expectation for the next cycle.
        if (rst_r) begin
          armed = 1; phase = P_IDLE; pc_m = '0;
          enb_m = 0; valid_m = 0; busy_m = 0; done_m = 0; err_m = 0;
        end else begin
          enb_m = 0;
          case (phase)
            P_IDLE: if (start_r) begin
              pc_m = base_r; done_m = 0; err_m = 0;
              enb_m = 1; addr_m = pc_m; busy_m = 1; fetch_cyc = cyc + 1; phase = P_FLIGHT;
            end
            P_FLIGHT: if (cyc + 1 == fetch_cyc + 2 + L) begin
              exp_m = decode(mem[pc_m[3:0]]);
              if (exp_m.kind == K_ISSUE) begin
                valid_m = 1; phase = P_ISSUE;
              end else begin
                busy_m = 0; phase = P_IDLE;
                if (exp_m.kind == K_END) done_m = 1;
                else                     err_m = 1;
              end
            end
            P_ISSUE: if (ready_r) begin
              valid_m = 0; pc_m = pc_m + 1;
              enb_m = 1; addr_m = pc_m; fetch_cyc = cyc + 1; phase = P_FLIGHT;
            end
            default: phase = P_IDLE;
          endcase
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start(input logic [31:0] base);
    base_r  = base;
    start_r = 1'b1;
    tick(1);
    start_r = 1'b0;
  endtask

  task automatic wait_main_valid(input int budget);
    int n = 0;
    while (!g_dut[1].u_if.instr_valid && n < budget) begin
      tick(1);
      n++;
    end
    check("valid timeout", g_dut[1].u_if.instr_valid, 1'b1);
  endtask

  task automatic wait_all_idle(input int budget);
    int n = 0;
    while ((g_dut[0].u_if.busy || g_dut[1].u_if.busy || g_dut[2].u_if.busy) && n < budget) begin
      tick(1);
      n++;
    end
    check("idle timeout", g_dut[0].u_if.busy | g_dut[1].u_if.busy | g_dut[2].u_if.busy, 1'b0);
  endtask

  initial begin
    int          vc0;
    logic [63:0] snap;
    for (int i = 0; i < 16; i++) mem[i] = W_END;
    tick(3);
    rst_r = 1'b0;
    check("reset busy",  g_dut[1].u_if.busy,        1'b0);
    check("reset done",  g_dut[1].u_if.done,        1'b0);
    check("reset error", g_dut[1].u_if.error,       1'b0);
    check("reset valid", g_dut[1].u_if.instr_valid, 1'b0);
    check("reset enb",   g_dut[1].u_if.bram_enb,    1'b0);
    tick(2);

    // 1: conv layer then END.
    mem[0] = W1; mem[1] = W_END; ready_r = 1'b1;
    vc0 = g_dut[1].valid_count;
    pulse_start(32'd0);
    wait_main_valid(20);
    check("t1 in_row",  g_dut[1].u_if.in_row,  10'd640);
    check("t1 out_row", g_dut[1].u_if.out_row, 10'd321);
    check("t1 out_col", g_dut[1].u_if.out_col, 10'd5);
    check("t1 in_ch",   g_dut[1].u_if.in_ch,   12'd20);
    check("t1 out_ch",  g_dut[1].u_if.out_ch,  12'd40);
    wait_all_idle(50);
    check("t1 done",   g_dut[1].u_if.done,  1'b1);
    check("t1 valids", 32'(g_dut[1].valid_count - vc0), 32'd1);

    // 2: back-pressure, plus a start while busy that must not move pc.
    mem[0] = W2; ready_r = 1'b0;
    pulse_start(32'd0);
    wait_main_valid(20);
    check("t2 out_row", g_dut[1].u_if.out_row, 10'd10);
    snap = {g_dut[1].u_if.in_row, g_dut[1].u_if.in_col, g_dut[1].u_if.out_row, g_dut[1].u_if.in_ch};
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin
        base_r  = 32'd5;
        start_r = 1'b1;
      end
      tick(1);
      start_r = 1'b0;
      check("t2 hold valid", g_dut[1].u_if.instr_valid, 1'b1);
      check("t2 hold enb",   g_dut[1].u_if.bram_enb,    1'b0);
      check("t2 hold fields",
            {g_dut[1].u_if.in_row, g_dut[1].u_if.in_col, g_dut[1].u_if.out_row, g_dut[1].u_if.in_ch}, snap);
    end
    ready_r = 1'b1;
    for (int n = 0; n < 5 && !g_dut[1].u_if.bram_enb; n++) tick(1);
    check("t2 next enb",  g_dut[1].u_if.bram_enb,   1'b1);
    check("t2 next addr", g_dut[1].u_if.bram_addrb, 32'd1);
    wait_all_idle(50);
    check("t2 done", g_dut[1].u_if.done, 1'b1);

    // 3: reserved opcode, then recovery.
    mem[0] = W_RSV;
    vc0 = g_dut[1].valid_count;
    pulse_start(32'd0);
    wait_all_idle(50);
    check("t3 error",  g_dut[1].u_if.error, 1'b1);
    check("t3 busy",   g_dut[1].u_if.busy,  1'b0);
    check("t3 valids", 32'(g_dut[1].valid_count - vc0), 32'd0);
    mem[0] = W2;
    pulse_start(32'd0);
    check("t3 error cleared", g_dut[1].u_if.error, 1'b0);
    wait_all_idle(50);
    check("t3 done", g_dut[1].u_if.done, 1'b1);

    // 4: kernel=2 is legal only without field checking.
    mem[0] = W_K2;
    vc0 = g_dut[1].valid_count;
    pulse_start(32'd0);
    wait_all_idle(50);
`ifdef IFD_FIELD_CHECK_EN
    check("t4 error",  g_dut[1].u_if.error, 1'b1);
    check("t4 valids", 32'(g_dut[1].valid_count - vc0), 32'd0);
`else
    check("t4 done",   g_dut[1].u_if.done,  1'b1);
    check("t4 valids", 32'(g_dut[1].valid_count - vc0), 32'd1);
`endif

    // 5: reset while waiting on BRAM abandons the fetch.
    mem[0] = W1;
    vc0 = g_dut[1].valid_count;
    pulse_start(32'd0);
    tick(1);
    rst_r = 1'b1;
    tick(1);
    check("t5 busy",  g_dut[1].u_if.busy,        1'b0);
    check("t5 valid", g_dut[1].u_if.instr_valid, 1'b0);
    check("t5 enb",   g_dut[1].u_if.bram_enb,    1'b0);
    check("t5 done",  g_dut[1].u_if.done,        1'b0);
    check("t5 addr",  g_dut[1].u_if.bram_addrb,  32'd0);
    rst_r = 1'b0;
    tick(15);
    check("t5 no stray valid", 32'(g_dut[1].valid_count - vc0), 32'd0);

    // 6: pc wrap and enb-to-valid latency per BRAM latency.
    mem[15] = W2; mem[0] = W_END;
    pulse_start(32'hFFFF_FFFF);
    wait_all_idle(60);
    check("t6 wrap addr", g_dut[1].u_if.bram_addrb, 32'd0);
    check("t6 done",      g_dut[1].u_if.done,       1'b1);
    check("t6 lat L1",    32'(g_dut[0].lat),        32'd3);
    check("t6 lat L2",    32'(g_dut[1].lat),        32'd4);
    check("t6 lat L3",    32'(g_dut[2].lat),        32'd5);

    tick(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog expired");
  end
endmodule
